// File: rtl/audio_port_pkg.sv
// Shared definitions for the audio serial ports: port framing modes and frame arithmetic.
package audio_port_pkg;

    typedef enum logic {
        MODE_I2S = 1'b0,
        MODE_TDM = 1'b1
    } port_mode_e;

    // Number of audio_clk cycles in one complete frame of all channel slots.
    function automatic int frame_cycles(input int num_ch, input int slot_w, input int bclk_div);
        return num_ch * slot_w * 2 * bclk_div;
    endfunction

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock generator: divides audio_clk down to BCLK and flags the cycles on which BCLK rises and falls.
module audio_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic audio_clk,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    if (BCLK_DIV < 2) begin : g_bad_div
        $error("audio_bclk_gen: BCLK_DIV must be at least 2");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;

    // The strobes mark the edge on which the registered BCLK is about to change level.
    always_comb begin
        div_wrap  = enable && (div_cnt == DIV_LAST);
        bclk_rise = div_wrap && !bclk;
        bclk_fall = div_wrap && bclk;
    end

    // Half-period counter; BCLK starts low so the first toggle after enable is a rising edge.
    always_ff @(posedge audio_clk) begin
        if (reset || !enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_tdm_port.sv
// Codec serial port master: generates MCLK/BCLK/LRCLK, serializes play samples and deserializes record samples.
module audio_tdm_port
    import audio_port_pkg::*;
#(
    parameter int         DATA_W   = 24,
    parameter int         NUM_CH   = 2,
    parameter int         SLOT_W   = 32,
    parameter int         BCLK_DIV = 4,
    parameter port_mode_e MODE     = MODE_I2S
) (
    input  logic                     audio_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     ADC_SDATA,
    input  logic [NUM_CH*DATA_W-1:0] PlayData,
    output logic                     MCLK,
    output logic                     BCLK,
    output logic                     LRCLK,
    output logic                     DAC_SDATA,
    output logic [NUM_CH*DATA_W-1:0] RecData,
    output logic                     NewFrame
);

    localparam int BUF_W      = NUM_CH * DATA_W;
    localparam int BIT_W      = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int SLOT_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W      = (BUF_W > 1) ? $clog2(BUF_W) : 1;

    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0]      DATA_LAST = BIT_W'(DATA_W);
    localparam logic [SLOT_IDX_W-1:0] SLOT_LAST = SLOT_IDX_W'(NUM_CH - 1);
    localparam logic [SLOT_IDX_W-1:0] SLOT_ONE  = SLOT_IDX_W'(1);

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("audio_tdm_port: NUM_CH must be in 2..8");
    end
    if (DATA_W < 1 || DATA_W + 1 > SLOT_W) begin : g_bad_slot
        $error("audio_tdm_port: need 1 <= DATA_W and DATA_W+1 <= SLOT_W");
    end
    if (BCLK_DIV < 2) begin : g_bad_div
        $error("audio_tdm_port: BCLK_DIV must be at least 2");
    end
    if (MODE == MODE_I2S && NUM_CH != 2) begin : g_bad_i2s
        $error("audio_tdm_port: MODE_I2S requires NUM_CH == 2");
    end

    // Buffer position of a data bit: slot field, MSB at bit_idx 1.
    function automatic logic [IDX_W-1:0] bit_pos(input logic [SLOT_IDX_W-1:0] slot,
                                                 input logic [BIT_W-1:0] bit_no);
        return IDX_W'(int'(slot) * DATA_W + DATA_W - int'(bit_no));
    endfunction

    logic                  bclk_rise;
    logic                  bclk_fall;
    logic [BIT_W-1:0]      bit_idx;
    logic [SLOT_IDX_W-1:0] slot_idx;
    logic [BIT_W-1:0]      next_bit;
    logic [SLOT_IDX_W-1:0] next_slot;
    logic                  started;
    logic                  have_frame;
    logic                  frame_wrap;
    logic                  frame_edge;
    logic                  cur_is_data;
    logic                  next_is_data;
    logic                  lr_next;
    logic [IDX_W-1:0]      tx_idx;
    logic [IDX_W-1:0]      rx_idx;
    logic [BUF_W-1:0]      tx_buf;
    logic [BUF_W-1:0]      rx_buf;

    audio_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .audio_clk (audio_clk),
        .reset     (reset),
        .enable    (enable),
        .bclk      (BCLK),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall)
    );

    // Slot position after the coming falling edge; the very first falling edge only enters slot 0 bit 0.
    always_comb begin
        next_bit  = bit_idx;
        next_slot = slot_idx;
        frame_wrap = started && (bit_idx == BIT_LAST) && (slot_idx == SLOT_LAST);
        frame_edge = !started || frame_wrap;
        if (!started) begin
            next_bit  = '0;
            next_slot = '0;
        end else if (bit_idx == BIT_LAST) begin
            next_bit  = '0;
            next_slot = (slot_idx == SLOT_LAST) ? '0 : slot_idx + 1'b1;
        end else begin
            next_bit  = bit_idx + 1'b1;
        end
        cur_is_data  = (bit_idx != '0) && (bit_idx <= DATA_LAST);
        next_is_data = (next_bit != '0) && (next_bit <= DATA_LAST);
        tx_idx       = bit_pos(next_slot, next_bit);
        rx_idx       = bit_pos(slot_idx, bit_idx);
        if (MODE == MODE_TDM) begin
            lr_next = (next_bit == BIT_LAST) && (next_slot == SLOT_LAST);
        end else begin
            lr_next = (next_slot == SLOT_ONE);
        end
    end

    // Serial engine: record on BCLK rise, advance and drive play data on BCLK fall, swap buffers at frame edges.
    always_ff @(posedge audio_clk) begin
        if (reset) begin
            MCLK       <= 1'b0;
            LRCLK      <= 1'b0;
            DAC_SDATA  <= 1'b0;
            NewFrame   <= 1'b0;
            RecData    <= '0;
            bit_idx    <= '0;
            slot_idx   <= '0;
            started    <= 1'b0;
            have_frame <= 1'b0;
            tx_buf     <= '0;
            rx_buf     <= '0;
        end else if (!enable) begin
            MCLK       <= 1'b0;
            LRCLK      <= 1'b0;
            DAC_SDATA  <= 1'b0;
            NewFrame   <= 1'b0;
            bit_idx    <= '0;
            slot_idx   <= '0;
            started    <= 1'b0;
            have_frame <= 1'b0;
            rx_buf     <= '0;
        end else begin
            MCLK     <= ~MCLK;
            NewFrame <= 1'b0;
            if (bclk_rise && started && cur_is_data) begin
                rx_buf[rx_idx] <= ADC_SDATA;
            end
            if (bclk_fall) begin
                bit_idx   <= next_bit;
                slot_idx  <= next_slot;
                started   <= 1'b1;
                LRCLK     <= lr_next;
                DAC_SDATA <= next_is_data ? tx_buf[tx_idx] : 1'b0;
                if (frame_edge) begin
                    tx_buf     <= PlayData;
                    have_frame <= 1'b1;
                    if (have_frame) begin
                        RecData  <= rx_buf;
                        NewFrame <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_tdm_port.sv
// Bench for audio_tdm_port: an I2S default instance and a 4-channel TDM instance, both in ADC loopback.
module tb_audio_tdm_port;
    import audio_port_pkg::*;

    localparam int DW      = 24;
    localparam int DIV_A   = 4;
    localparam int CH_A    = 2;
    localparam int DIV_T   = 2;
    localparam int CH_T    = 4;
    localparam int SLOT    = 32;
    localparam int FRAME_A = frame_cycles(CH_A, SLOT, DIV_A);
    localparam int FRAME_T = frame_cycles(CH_T, SLOT, DIV_T);

    typedef struct packed {
        logic mclk;
        logic bclk;
        logic lrclk;
        logic dac;
        logic nf;
    } outs_t;

    typedef struct {
        int          cycles;
        bit          rst;
        bit          en;
        logic [47:0] play;
        logic [47:0] exp_rec;
        int          exp_nf;
        int          exp_lr_a;
        int          exp_lr_t;
    } phase_t;

    logic        audio_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [47:0] play_a;
    logic [95:0] play_t;

    logic        mclk_a, bclk_a, lrclk_a, dac_a, nf_a;
    logic [47:0] rec_a;
    logic        mclk_t, bclk_t, lrclk_t, dac_t, nf_t;
    logic [95:0] rec_t;

    int vectors = 0;
    int miscompares = 0;
    int fail_prints = 0;
    int nf_cnt = 0;
    int lr_hi_a = 0;
    int lr_hi_t = 0;

    int          k_a = -1;
    int          k_t = -1;
    logic [95:0] lat_a = '0;
    logic [95:0] lat_t = '0;
    logic [95:0] recm_a = '0;
    logic [95:0] recm_t = '0;
    bit          nfm_a;
    bit          nfm_t;

    always #5 audio_clk = ~audio_clk;

    audio_tdm_port #(
        .DATA_W(DW), .NUM_CH(CH_A), .SLOT_W(SLOT), .BCLK_DIV(DIV_A), .MODE(MODE_I2S)
    ) dut_a (
        .audio_clk (audio_clk),
        .reset     (reset),
        .enable    (enable),
        .ADC_SDATA (dac_a),
        .PlayData  (play_a),
        .MCLK      (mclk_a),
        .BCLK      (bclk_a),
        .LRCLK     (lrclk_a),
        .DAC_SDATA (dac_a),
        .RecData   (rec_a),
        .NewFrame  (nf_a)
    );

    audio_tdm_port #(
        .DATA_W(DW), .NUM_CH(CH_T), .SLOT_W(SLOT), .BCLK_DIV(DIV_T), .MODE(MODE_TDM)
    ) dut_t (
        .audio_clk (audio_clk),
        .reset     (reset),
        .enable    (enable),
        .ADC_SDATA (dac_t),
        .PlayData  (play_t),
        .MCLK      (mclk_t),
        .BCLK      (bclk_t),
        .LRCLK     (lrclk_t),
        .DAC_SDATA (dac_t),
        .RecData   (rec_t),
        .NewFrame  (nf_t)
    );

    // Frame-level reference: k counts enabled cycles, frames latch play data, loopback returns the previous frame.
    task automatic model_step(input bit rst, input bit en, input logic [95:0] play,
                              input int frame, input int div,
                              inout int k, inout logic [95:0] lat, inout logic [95:0] rec,
                              output bit nf);
        nf = 1'b0;
        if (rst) begin
            k   = -1;
            rec = '0;
            lat = '0;
        end else if (!en) begin
            k = -1;
        end else begin
            k++;
            if ((k + 1) % frame == 2 * div) begin
                if (k + 1 > frame) begin
                    nf  = 1'b1;
                    rec = lat;
                end
                lat = play;
            end
        end
    endtask

    // Expected pin levels k cycles into a run, derived from the clock ratios and slot layout.
    function automatic outs_t expect_outs(input int k, input int div, input int num_ch,
                                          input bit tdm, input logic [95:0] lat, input bit nf);
        outs_t o;
        int f, p, b, s;
        o = '0;
        if (k < 0) return o;
        o.mclk = ((k + 1) % 2) == 1;
        o.bclk = (((k + 1) / div) % 2) == 1;
        f = (k + 1) / (2 * div);
        if (f > 0) begin
            p = f - 1;
            b = p % SLOT;
            s = (p / SLOT) % num_ch;
            if (b >= 1 && b <= DW) o.dac = lat[s * DW + (DW - b)];
            o.lrclk = tdm ? (b == SLOT - 1 && s == num_ch - 1) : (s == 1);
        end
        o.nf = nf;
        return o;
    endfunction

    task automatic checkOutput(input string name, input outs_t got, input outs_t exp,
                               input logic [95:0] grec, input logic [95:0] erec);
        vectors++;
        if (got !== exp || grec !== erec) begin
            miscompares++;
            if (fail_prints < 12) begin
                fail_prints++;
                $display("[TB] FAIL %s t=%0t: got mclk/bclk/lrclk/dac/nf=%b rec=%h, want %b rec=%h",
                         name, $time, got, grec, exp, erec);
            end
        end
    endtask

    // Per-cycle comparison of both instances against the reference, sampled 1 time unit after the edge.
    always @(posedge audio_clk) begin
        model_step(reset, enable, {48'b0, play_a}, FRAME_A, DIV_A, k_a, lat_a, recm_a, nfm_a);
        model_step(reset, enable, play_t, FRAME_T, DIV_T, k_t, lat_t, recm_t, nfm_t);
        #1;
        checkOutput("i2s_pins", {mclk_a, bclk_a, lrclk_a, dac_a, nf_a},
                    expect_outs(k_a, DIV_A, CH_A, 1'b0, lat_a, nfm_a), {48'b0, rec_a}, recm_a);
        checkOutput("tdm_pins", {mclk_t, bclk_t, lrclk_t, dac_t, nf_t},
                    expect_outs(k_t, DIV_T, CH_T, 1'b1, lat_t, nfm_t), rec_t, recm_t);
        nf_cnt  += int'(nf_a);
        lr_hi_a += int'(lrclk_a);
        lr_hi_t += int'(lrclk_t);
    end

    task automatic checkPhase(input int idx, input string what, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL phase%0d %s: got %0d, want %0d", idx, what, got, want);
        end
    endtask

    task automatic applyStimulus(input phase_t ph);
        reset   = ph.rst;
        enable  = ph.en;
        play_a  = ph.play;
        nf_cnt  = 0;
        lr_hi_a = 0;
        lr_hi_t = 0;
        repeat (ph.cycles) @(negedge audio_clk);
    endtask

    phase_t      phases[13];
    logic [63:0] r;
    logic [47:0] val_a, val_b, val_c, val_d, val_e;

    initial begin
        val_a  = 48'h800001_ABCDEF;
        r = {$urandom(), $urandom()}; val_b = r[47:0];
        r = {$urandom(), $urandom()}; val_c = r[47:0];
        r = {$urandom(), $urandom()}; val_d = r[47:0];
        r = {$urandom(), $urandom()}; val_e = r[47:0];
        play_t = {24'd4, 24'd3, 24'd2, 24'd1};

        //            cycles rst en  play   exp_rec exp_nf lr_a lr_t
        phases[0]  = '{4,    1, 0, 48'h0, 48'h0, 0, -1,  -1};
        phases[1]  = '{1100, 0, 1, val_a, val_a, 2, 512, 8};
        phases[2]  = '{512,  0, 1, val_b, val_a, 1, -1,  -1};
        phases[3]  = '{512,  0, 1, val_b, val_b, 1, -1,  -1};
        phases[4]  = '{231,  0, 1, val_b, val_b, 0, -1,  -1};
        phases[5]  = '{50,   0, 0, val_b, val_b, 0, 0,   0};
        phases[6]  = '{519,  0, 1, val_c, val_b, 0, -1,  -1};
        phases[7]  = '{1,    0, 1, val_c, val_c, 1, -1,  -1};
        phases[8]  = '{200,  0, 1, val_d, val_c, 0, -1,  -1};
        phases[9]  = '{1,    1, 1, val_d, 48'h0, 0, 0,   0};
        phases[10] = '{519,  0, 1, val_a, 48'h0, 0, -1,  -1};
        phases[11] = '{1,    0, 1, val_a, val_a, 1, -1,  -1};
        phases[12] = '{1024, 0, 1, val_e, val_e, 2, -1,  -1};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(phases[i]);
            checkPhase(i, "RecData_lo", int'(rec_a[23:0]), int'(phases[i].exp_rec[23:0]));
            checkPhase(i, "RecData_hi", int'(rec_a[47:24]), int'(phases[i].exp_rec[47:24]));
            checkPhase(i, "NewFrame_count", nf_cnt, phases[i].exp_nf);
            if (phases[i].exp_lr_a >= 0) checkPhase(i, "i2s_lrclk_high", lr_hi_a, phases[i].exp_lr_a);
            if (phases[i].exp_lr_t >= 0) checkPhase(i, "tdm_lrclk_high", lr_hi_t, phases[i].exp_lr_t);
        end

        for (int c = 0; c < CH_T; c++) begin
            checkPhase(99, $sformatf("tdm_ch%0d", c), int'(rec_t[c*DW +: DW]), c + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
